// File: rtl/systolic_output_collector_pkg.sv
// Shared definitions for the systolic output collector: FSM state encodings
// and the word-slice helper used when addressing a column inside a bus.
package systolic_output_collector_pkg;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_WAIT    = 2'b01;
  localparam logic [1:0] ST_CAPTURE = 2'b10;

  // Bit offset of column c's word within a packed COLS*word_size bus.
  function automatic int word_lsb(input int c, input int word_size);
    return c * word_size;
  endfunction

endpackage

// File: rtl/systolic_output_collector_fifo.sv
// Synchronous first-word-fall-through FIFO. A push into a full FIFO only
// succeeds when a pop happens in the same cycle; otherwise it is discarded.
module collector_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic [WIDTH-1:0]           data_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Head falls through; once drained, the last word read stays on the output.
  assign data_o = empty_o ? last_q : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      last_d   = mem_q[rd_ptr_q];
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  // NOTE: storage has no reset; it is never observed before being written
  // because empty_o steers the output to last_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/systolic_output_collector.sv
// Bottom-edge reader of the systolic array: deskews columns, packs each result
// row into one vector and buffers it for the writeback stream.
module systolic_output_collector
  import systolic_output_collector_pkg::*;
#(
  parameter int ROWS       = 32,
  parameter int COLS       = 32,
  parameter int WORD_SIZE  = 16,
  parameter int PIPE_LAT   = ROWS,
  parameter int MAX_VECS   = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_in,
  input  logic [$clog2(MAX_VECS+1)-1:0]   num_vecs_in,
  input  logic [COLS*WORD_SIZE-1:0]       bottom_in_bus,
  output logic                            busy_out,
  output logic                            done_out,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [COLS*WORD_SIZE-1:0]       out_data,
  output logic                            overflow_err
);

  localparam int NVW       = $clog2(MAX_VECS + 1);
  localparam int BW        = COLS * WORD_SIZE;
  // WAIT lasts PIPE_LAT+COLS-2 cycles so CAPTURE begins exactly at TA(0).
  localparam int WAIT_LOAD = PIPE_LAT + COLS - 3;
  localparam int WCW       = $clog2(PIPE_LAT + COLS);

  logic [BW-1:0] aligned;

  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int D   = COLS - 1 - c;
    localparam int LSB = word_lsb(c, WORD_SIZE);
    if (D == 0) begin : g_thru
      assign aligned[LSB +: WORD_SIZE] = bottom_in_bus[LSB +: WORD_SIZE];
    end else begin : g_dly
      logic [WORD_SIZE-1:0] dly_q [D];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < D; i++) dly_q[i] <= '0;
        end else begin
          dly_q[0] <= bottom_in_bus[LSB +: WORD_SIZE];
          for (int i = 1; i < D; i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign aligned[LSB +: WORD_SIZE] = dly_q[D-1];
    end
  end

  logic [1:0]     state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [NVW-1:0] vec_cnt_q, vec_cnt_d;
  logic [NVW-1:0] num_vecs_q, num_vecs_d;
  logic           zero_done_q, zero_done_d;
  logic           overflow_q, overflow_d;

  logic           start_acc, push, last_vec, pop, drop;
  logic           fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count;

  assign start_acc = start_in && (state_q == ST_IDLE);
  assign push      = (state_q == ST_CAPTURE);
  assign last_vec  = push && (vec_cnt_q == num_vecs_q - NVW'(1));
  assign pop       = out_valid && out_ready;
  assign drop      = push && fifo_full && !pop;

  assign busy_out     = (state_q != ST_IDLE);
  assign done_out     = zero_done_q || last_vec;
  assign out_valid    = !fifo_empty;
  assign overflow_err = overflow_q;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    vec_cnt_d   = vec_cnt_q;
    num_vecs_d  = num_vecs_q;
    zero_done_d = 1'b0;
    overflow_d  = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          num_vecs_d = num_vecs_in;
          vec_cnt_d  = '0;
          overflow_d = 1'b0;
          if (num_vecs_in == '0) begin
            zero_done_d = 1'b1;
          end else begin
            state_d    = ST_WAIT;
            wait_cnt_d = WCW'(WAIT_LOAD);
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == '0) state_d = ST_CAPTURE;
        else                  wait_cnt_d = wait_cnt_q - WCW'(1);
      end
      ST_CAPTURE: begin
        // A dropped vector still consumes its slot: the array cannot wait.
        vec_cnt_d = vec_cnt_q + NVW'(1);
        if (drop) overflow_d = 1'b1;
        if (last_vec) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      vec_cnt_q   <= '0;
      num_vecs_q  <= '0;
      zero_done_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      vec_cnt_q   <= vec_cnt_d;
      num_vecs_q  <= num_vecs_d;
      zero_done_q <= zero_done_d;
      overflow_q  <= overflow_d;
    end
  end

  collector_fifo #(
    .WIDTH (BW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (aligned),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .data_o  (out_data)
  );

  logic unused_ok;
  assign unused_ok = ^{fifo_count, start_acc};

endmodule

// File: tb/tb_systolic_output_collector.sv
// Randomized bench for systolic_output_collector: a timestamp/queue model of
// the tile schedule and output buffer predicts every output each cycle.
module tb_systolic_output_collector;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int W     = 16;
  localparam int PIPE  = 4;
  localparam int MAXV  = 256;
  localparam int DEPTH = 4;
  localparam int NVW   = $clog2(MAXV + 1);
  localparam int BW    = COLS * W;
  localparam int MAXK  = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_in;
  logic [NVW-1:0] num_vecs_in;
  logic [BW-1:0]  bottom_in_bus;
  logic           busy_out, done_out, out_valid, out_ready, overflow_err;
  logic [BW-1:0]  out_data;

  always #5 clk = ~clk;

  systolic_output_collector #(
    .ROWS(ROWS), .COLS(COLS), .WORD_SIZE(W), .PIPE_LAT(PIPE),
    .MAX_VECS(MAXV), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .num_vecs_in(num_vecs_in),
    .bottom_in_bus(bottom_in_bus), .busy_out(busy_out), .done_out(done_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .overflow_err(overflow_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: the current tile by start cycle and count, plus a queue
  // standing in for the output buffer.
  bit            tile_on = 1'b0;
  bit            pattern = 1'b0;
  int            t0 = 0;
  int            nv = 0;
  logic [W-1:0]  tdata [MAXK][COLS];
  logic [BW-1:0] q [$];
  logic [BW-1:0] last_pop = '0;
  bit            ovf = 1'b0;

  function automatic bit m_busy(input int t);
    return tile_on && nv > 0 && t >= t0 + 1 && t <= t0 + PIPE + COLS - 2 + nv;
  endfunction

  function automatic bit m_done(input int t);
    return tile_on && ((nv == 0 && t == t0 + 1) ||
                       (nv > 0 && t == t0 + PIPE + COLS - 2 + nv));
  endfunction

  function automatic logic [BW-1:0] vec(input int k);
    logic [BW-1:0] v;
    for (int c = 0; c < COLS; c++) v[c*W +: W] = tdata[k][c];
    return v;
  endfunction

  task automatic drive_bus();
    for (int c = 0; c < COLS; c++) begin
      int k;
      k = cyc - (t0 + PIPE + c);
      if (tile_on && k >= 0 && k < nv) bottom_in_bus[c*W +: W] = tdata[k][c];
      else                             bottom_in_bus[c*W +: W] = W'($urandom);
    end
  endtask

  task automatic compare();
    check("busy_out", busy_out, m_busy(cyc));
    check("done_out", done_out, m_done(cyc));
    check("out_valid", out_valid, q.size() != 0);
    check("out_data", out_data, (q.size() != 0) ? q[0] : last_pop);
    check("overflow_err", overflow_err, ovf);
  endtask

  task automatic update();
    int  k;
    bit  push, pop, accept;
    if (rst) begin
      q.delete();
      last_pop = '0;
      ovf      = 1'b0;
      tile_on  = 1'b0;
      return;
    end
    k      = cyc - (t0 + PIPE + COLS - 1);
    push   = tile_on && nv > 0 && k >= 0 && k < nv;
    pop    = q.size() != 0 && out_ready;
    accept = start_in && !m_busy(cyc);
    if (pop) last_pop = q.pop_front();
    if (push) begin
      if (q.size() < DEPTH) q.push_back(vec(k));
      else                  ovf = 1'b1;
    end
    if (accept) begin
      ovf     = 1'b0;
      t0      = cyc;
      nv      = int'(num_vecs_in);
      tile_on = 1'b1;
      for (int kk = 0; kk < MAXK; kk++)
        for (int c = 0; c < COLS; c++)
          tdata[kk][c] = pattern ? {8'(kk), 8'(c)} : W'($urandom);
    end
  endtask

  task automatic run_cycle();
    drive_bus();
    @(negedge clk);
    compare();
    update();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    start_in = 1'b0;
    repeat (n) run_cycle();
  endtask

  task automatic start_tile(input int n);
    start_in    = 1'b1;
    num_vecs_in = NVW'(n);
    run_cycle();
    start_in    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_in = 1'b0; num_vecs_in = '0; out_ready = 1'b1; bottom_in_bus = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Skew drive with recognisable words 16'h0k0c.
    pattern = 1'b1;
    idle(2);
    start_tile(3);
    idle(12);
    pattern = 1'b0;

    // Backpressure: four vectors held, then drained in order.
    out_ready = 1'b0;
    start_tile(4);
    idle(12);
    out_ready = 1'b1;
    idle(8);

    // Overflow: vectors 4 and 5 dropped; next start clears the flag.
    out_ready = 1'b0;
    start_tile(6);
    idle(14);
    @(negedge clk);
    check("overflow_sticky", overflow_err, 1'b1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    idle(6);
    start_tile(1);
    idle(10);

    // Full FIFO with push and pop in the same cycle.
    out_ready = 1'b0;
    start_tile(6);
    idle(10);
    out_ready = 1'b1;
    idle(10);

    // Zero-length tile, then a start during busy that must be ignored.
    start_tile(0);
    idle(3);
    start_tile(3);
    idle(2);
    start_tile(7);
    idle(12);

    // Reset in the middle of a tile, then a normal tile.
    pattern = 1'b1;
    start_tile(3);
    idle(5);
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    idle(3);
    start_tile(2);
    idle(12);
    pattern = 1'b0;

    // Random traffic: ready stalls, random lengths, starts at arbitrary times.
    for (int i = 0; i < 400; i++) begin
      out_ready   = ($urandom_range(0, 3) != 0);
      start_in    = ($urandom_range(0, 7) == 0);
      num_vecs_in = NVW'($urandom_range(0, 7));
      run_cycle();
    end
    start_in  = 1'b0;
    out_ready = 1'b1;
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
